// File: rtl/boot_pkg.sv
// Shared definitions for the boot sequencer: FSM state encodings and the
// default load-stability window.
package boot_pkg;

  // Boot sequencer states; the numeric values are visible on o_state.
  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_READY = 2'd1,
    ST_RUN   = 2'd2,
    ST_HALT  = 2'd3
  } boot_state_e;

  // Consecutive i_transmit_done-high cycles needed before the ROM image is trusted.
  localparam int DONE_STABLE_DEF = 16;

endpackage : boot_pkg

// File: rtl/boot_seq_ctrl_if.sv
// ROM read-port bus: CPU and debug requesters on one side, the boot
// sequencer (arbiter and ROM address/enable driver) on the other.
interface boot_seq_ctrl_if #(
  parameter int ADDR_W = 8
);

  logic              i_cpu_req;
  logic [ADDR_W-1:0] i_cpu_addr;
  logic              i_dbg_req;
  logic [ADDR_W-1:0] i_dbg_addr;
  logic              o_cpu_gnt;
  logic              o_dbg_gnt;
  logic              o_cpu_rvalid;
  logic              o_dbg_rvalid;
  logic              o_rom_en_read;
  logic [ADDR_W-1:0] o_rom_addr;

  // Requester side: CPU fetch unit, debug port and the ROM itself.
  modport master (
    output i_cpu_req, i_cpu_addr, i_dbg_req, i_dbg_addr,
    input  o_cpu_gnt, o_dbg_gnt, o_cpu_rvalid, o_dbg_rvalid,
    input  o_rom_en_read, o_rom_addr
  );

  // Controller side: the boot sequencer.
  modport slave (
    input  i_cpu_req, i_cpu_addr, i_dbg_req, i_dbg_addr,
    output o_cpu_gnt, o_dbg_gnt, o_cpu_rvalid, o_dbg_rvalid,
    output o_rom_en_read, o_rom_addr
  );

endinterface : boot_seq_ctrl_if

// File: rtl/rom_rd_arbiter.sv
// Single-port ROM read arbiter. Grants depend on the boot state: nothing
// while the ROM is loading, debug only while the CPU is held in reset, and
// CPU-first while running. rvalid follows each grant by one cycle to match
// the ROM's synchronous read.
module rom_rd_arbiter
  import boot_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  boot_state_e     state,
  boot_seq_ctrl_if.slave  bus
);

  logic cpu_gnt;
  logic dbg_gnt;
  logic cpu_rvalid_reg;
  logic dbg_rvalid_reg;

  // Grant selection from the current state and the live requests.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    unique case (state)
      ST_RUN: begin
        cpu_gnt = bus.i_cpu_req;
        dbg_gnt = bus.i_dbg_req & ~bus.i_cpu_req;
      end
      ST_READY, ST_HALT: dbg_gnt = bus.i_dbg_req;
      default: ;
    endcase
  end

  assign bus.o_cpu_gnt     = cpu_gnt;
  assign bus.o_dbg_gnt     = dbg_gnt;
  assign bus.o_rom_en_read = cpu_gnt | dbg_gnt;
  assign bus.o_rom_addr    = cpu_gnt ? bus.i_cpu_addr :
                             dbg_gnt ? bus.i_dbg_addr : '0;

  // One-cycle rvalid pipeline; independent of the next state so a grant in
  // the last RUN cycle still gets its data flagged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cpu_rvalid_reg <= 1'b0;
      dbg_rvalid_reg <= 1'b0;
    end else begin
      cpu_rvalid_reg <= cpu_gnt;
      dbg_rvalid_reg <= dbg_gnt;
    end
  end

  assign bus.o_cpu_rvalid = cpu_rvalid_reg;
  assign bus.o_dbg_rvalid = dbg_rvalid_reg;

endmodule : rom_rd_arbiter

// File: rtl/boot_seq_ctrl.sv
// Boot sequencer: waits for a stable ROM load, then releases the CPU from
// reset on i_start, halts it on a halt instruction or an out-of-image fetch,
// and arbitrates ROM reads between the CPU and the debug port.
module boot_seq_ctrl
  import boot_pkg::*;
#(
  parameter int DONE_STABLE = DONE_STABLE_DEF,
  parameter int ADDR_W      = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_transmit_done,
  input  logic [ADDR_W-1:0] i_max_addr,
  input  logic              i_start,
  input  logic              i_cpu_halt,
  output logic              o_cpu_rst_n,
  output logic [1:0]        o_state,
  output logic              o_addr_fault,
  boot_seq_ctrl_if.slave    bus
);

  localparam int CNT_W = $clog2(DONE_STABLE + 1);

  boot_state_e      state_reg;
  logic [CNT_W-1:0] stable_cnt_reg;
  logic             cpu_rst_n_reg;
  logic             addr_fault_reg;
  logic             fetch_fault;
  logic             load_ok;

  // A granted CPU fetch past the last loaded word is a fault.
  assign fetch_fault = bus.o_cpu_gnt & (bus.i_cpu_addr > i_max_addr);

  // Load accepted on the cycle the done flag completes its stable window,
  // provided the image is non-empty.
  assign load_ok = i_transmit_done
                 & (stable_cnt_reg >= CNT_W'(DONE_STABLE - 1))
                 & (i_max_addr != '0);

  // Boot FSM with registered CPU reset, fault flag and stability counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= ST_LOAD;
      stable_cnt_reg <= '0;
      cpu_rst_n_reg  <= 1'b0;
      addr_fault_reg <= 1'b0;
    end else begin
      if (!i_transmit_done)
        stable_cnt_reg <= '0;
      else if (stable_cnt_reg != CNT_W'(DONE_STABLE))
        stable_cnt_reg <= stable_cnt_reg + 1'b1;

      unique case (state_reg)
        ST_LOAD: begin
          cpu_rst_n_reg <= 1'b0;
          if (load_ok) state_reg <= ST_READY;
        end
        ST_READY, ST_HALT: begin
          if (i_start) begin
            state_reg      <= ST_RUN;
            cpu_rst_n_reg  <= 1'b1;
            addr_fault_reg <= 1'b0;
          end else begin
            cpu_rst_n_reg  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (i_cpu_halt || fetch_fault) begin
            state_reg     <= ST_HALT;
            cpu_rst_n_reg <= 1'b0;
            if (fetch_fault) addr_fault_reg <= 1'b1;
          end else begin
            cpu_rst_n_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_LOAD;
      endcase
    end
  end

  assign o_state      = state_reg;
  assign o_cpu_rst_n  = cpu_rst_n_reg;
  assign o_addr_fault = addr_fault_reg;

  rom_rd_arbiter #(
    .ADDR_W (ADDR_W)
  ) u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .state   (state_reg),
    .bus     (bus)
  );

endmodule : boot_seq_ctrl

// File: tb/tb_boot_seq_ctrl.sv
// Directed bench for the boot sequencer: load window, arbitration in each
// state, address fault, halt, restart and asynchronous reset.
module tb_boot_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       transmit_done;
  logic [7:0] max_addr;
  logic       start;
  logic       cpu_halt;
  logic       cpu_rst_n;
  logic [1:0] state;
  logic       addr_fault;

  int n_vec  = 0;
  int n_miss = 0;

  boot_seq_ctrl_if #(.ADDR_W(8)) bus_if ();

  boot_seq_ctrl #(
    .DONE_STABLE (16),
    .ADDR_W      (8)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_transmit_done (transmit_done),
    .i_max_addr      (max_addr),
    .i_start         (start),
    .i_cpu_halt      (cpu_halt),
    .o_cpu_rst_n     (cpu_rst_n),
    .o_state         (state),
    .o_addr_fault    (addr_fault),
    .bus             (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges and land 1 time unit after the last one.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic cr, input logic [7:0] ca, input logic dr, input logic [7:0] da);
    bus_if.i_cpu_req  = cr;
    bus_if.i_cpu_addr = ca;
    bus_if.i_dbg_req  = dr;
    bus_if.i_dbg_addr = da;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; transmit_done = 1'b0; max_addr = 8'h00;
    start = 1'b0; cpu_halt = 1'b0;
    set_req(1'b0, 8'h00, 1'b0, 8'h00);
    cycles(3);
    check_vec("rst_state", state, 0);
    check_vec("rst_cpu_rst_n", cpu_rst_n, 0);
    check_vec("rst_fault", addr_fault, 0);
    check_vec("rst_cpu_rvalid", bus_if.o_cpu_rvalid, 0);
    rst_n = 1'b1;

    // Empty image: done high forever, still LOAD; no grants while loading.
    transmit_done = 1'b1;
    set_req(1'b1, 8'h01, 1'b1, 8'h02);
    cycles(20);
    check_vec("load_maxaddr0_state", state, 0);
    check_vec("load_dbg_gnt", bus_if.o_dbg_gnt, 0);
    check_vec("load_cpu_gnt", bus_if.o_cpu_gnt, 0);
    check_vec("load_rom_en", bus_if.o_rom_en_read, 0);
    set_req(1'b0, 8'h00, 1'b0, 8'h00);

    // 15 high, 1 low, 16 high -> READY only after the second window.
    transmit_done = 1'b0; max_addr = 8'h20;
    cycles(1);
    transmit_done = 1'b1;
    cycles(15);
    check_vec("load_15_state", state, 0);
    transmit_done = 1'b0;
    cycles(1);
    transmit_done = 1'b1;
    cycles(15);
    check_vec("load_gap_15_state", state, 0);
    cycles(1);
    check_vec("load_gap_16_state", state, 1);
    check_vec("ready_cpu_rst_n", cpu_rst_n, 0);

    // READY: debug only, even with a CPU request present.
    set_req(1'b1, 8'h05, 1'b1, 8'h03);
    #4;
    check_vec("ready_dbg_gnt", bus_if.o_dbg_gnt, 1);
    check_vec("ready_cpu_gnt", bus_if.o_cpu_gnt, 0);
    check_vec("ready_rom_addr", bus_if.o_rom_addr, 8'h03);
    check_vec("ready_rom_en", bus_if.o_rom_en_read, 1);
    cycles(1);
    set_req(1'b0, 8'h00, 1'b0, 8'h00);
    check_vec("ready_dbg_rvalid", bus_if.o_dbg_rvalid, 1);
    check_vec("ready_cpu_rvalid", bus_if.o_cpu_rvalid, 0);
    #4;
    check_vec("idle_rom_addr", bus_if.o_rom_addr, 8'h00);
    cycles(1);
    check_vec("ready_dbg_rvalid_drop", bus_if.o_dbg_rvalid, 0);

    // Start -> RUN.
    pulse_start();
    check_vec("run_state", state, 2);
    check_vec("run_cpu_rst_n", cpu_rst_n, 1);

    // Start ignored in RUN.
    pulse_start();
    check_vec("run_start_ignored", state, 2);

    // RUN: CPU wins over debug.
    set_req(1'b1, 8'h05, 1'b1, 8'h10);
    #4;
    check_vec("run_cpu_gnt", bus_if.o_cpu_gnt, 1);
    check_vec("run_dbg_gnt", bus_if.o_dbg_gnt, 0);
    check_vec("run_rom_addr", bus_if.o_rom_addr, 8'h05);
    cycles(1);
    set_req(1'b0, 8'h00, 1'b1, 8'h10);
    check_vec("run_cpu_rvalid", bus_if.o_cpu_rvalid, 1);
    check_vec("run_dbg_rvalid0", bus_if.o_dbg_rvalid, 0);
    #4;
    check_vec("run_dbg_alone_gnt", bus_if.o_dbg_gnt, 1);
    check_vec("run_dbg_alone_addr", bus_if.o_rom_addr, 8'h10);
    cycles(1);
    check_vec("run_dbg_rvalid", bus_if.o_dbg_rvalid, 1);

    // Fetch exactly at max_addr is legal.
    set_req(1'b1, 8'h20, 1'b0, 8'h00);
    cycles(1);
    check_vec("run_at_max_state", state, 2);
    check_vec("run_at_max_fault", addr_fault, 0);

    // Fetch beyond max_addr -> HALT with fault; last grant still gets rvalid.
    set_req(1'b1, 8'h21, 1'b0, 8'h00);
    cycles(1);
    set_req(1'b0, 8'h00, 1'b0, 8'h00);
    check_vec("fault_state", state, 3);
    check_vec("fault_flag", addr_fault, 1);
    check_vec("fault_cpu_rst_n", cpu_rst_n, 0);
    check_vec("fault_last_rvalid", bus_if.o_cpu_rvalid, 1);
    set_req(1'b1, 8'h04, 1'b0, 8'h00);
    #4;
    check_vec("halt_cpu_gnt", bus_if.o_cpu_gnt, 0);
    set_req(1'b0, 8'h00, 1'b0, 8'h00);
    pulse_start();
    check_vec("restart_state", state, 2);
    check_vec("restart_fault_clr", addr_fault, 0);
    check_vec("restart_cpu_rst_n", cpu_rst_n, 1);

    // Plain halt: no fault.
    cpu_halt = 1'b1;
    cycles(1);
    cpu_halt = 1'b0;
    check_vec("halt_state", state, 3);
    check_vec("halt_no_fault", addr_fault, 0);

    // Halt and fault in the same cycle -> HALT with fault.
    pulse_start();
    cpu_halt = 1'b1;
    set_req(1'b1, 8'h30, 1'b0, 8'h00);
    cycles(1);
    cpu_halt = 1'b0;
    set_req(1'b0, 8'h00, 1'b0, 8'h00);
    check_vec("halt_fault_state", state, 3);
    check_vec("halt_fault_flag", addr_fault, 1);

    // Asynchronous reset mid-RUN with an rvalid pending.
    pulse_start();
    set_req(1'b1, 8'h07, 1'b0, 8'h00);
    cycles(1);
    set_req(1'b0, 8'h00, 1'b0, 8'h00);
    check_vec("pre_rst_rvalid", bus_if.o_cpu_rvalid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_vec("async_rst_state", state, 0);
    check_vec("async_rst_cpu_rst_n", cpu_rst_n, 0);
    check_vec("async_rst_rvalid", bus_if.o_cpu_rvalid, 0);
    #1;
    rst_n = 1'b1;
    cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_boot_seq_ctrl
